antares_count_leading: RTL

//  Multi-cycle count-leading-zeros/ones unit (MIPS32 CLZ/CLO) for the Antares EX stage.

---
 rtl/antares_count_leading_pkg.sv | 16 +
 rtl/antares_clz_chunk_encoder.sv | 25 ++
 rtl/antares_count_leading.sv | 120 ++++++++++++
 3 files changed

// File: rtl/antares_count_leading_pkg.sv
// Shared encodings for the Antares count-leading-zeros/ones unit:
// FSM states, operation codes and result width.
package antares_count_leading_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_SCAN = 2'd1,
        ST_DONE = 2'd2
    } clz_state_t;

    localparam logic CLZ_OP_CLZ = 1'b0;
    localparam logic CLZ_OP_CLO = 1'b1;

    localparam int CLZ_RESULT_W = 6;

endpackage

// File: rtl/antares_clz_chunk_encoder.sv
// Combinational priority encoder: leading-zero count of one SCAN_WIDTH-bit chunk
// plus a nonzero flag. lz reads SCAN_WIDTH when the chunk is all zero.
module antares_clz_chunk_encoder
    import antares_count_leading_pkg::*;
#(
    parameter int SCAN_WIDTH = 4
) (
    input  logic [SCAN_WIDTH-1:0]   chunk,
    output logic [CLZ_RESULT_W-1:0] lz,
    output logic                    nonzero
);

    // Walk LSB upward so the highest set bit is the last one to write lz.
    always_comb begin
        lz = CLZ_RESULT_W'(SCAN_WIDTH);
        for (int i = 0; i < SCAN_WIDTH; i++) begin
            if (chunk[i]) begin
                lz = CLZ_RESULT_W'(SCAN_WIDTH - 1 - i);
            end
        end
    end

    assign nonzero = |chunk;

endmodule

// File: rtl/antares_count_leading.sv
// Multi-cycle CLZ/CLO unit with start/busy/done handshake and flush.
// Build option: ANTARES_CLZ_EARLY_EXIT_EN ends the scan on the first nonzero chunk.
//
//   state | meaning
//   IDLE  | waiting for clz_start; operand latched on start
//   SCAN  | one chunk of shreg examined per cycle
//   DONE  | clz_result valid, clz_done pulses, back to IDLE
module antares_count_leading
    import antares_count_leading_pkg::*;
#(
    parameter int SCAN_WIDTH = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        clz_start,
    input  logic        clz_op,
    input  logic [31:0] clz_input_data,
    input  logic        clz_flush,
    output logic        clz_busy,
    output logic        clz_done,
    output logic [31:0] clz_result
);

    localparam int ITERS  = 32 / SCAN_WIDTH;
    localparam int ITER_W = $clog2(ITERS);
    localparam logic [ITER_W-1:0]       LAST_ITER = ITER_W'(ITERS - 1);
    localparam logic [CLZ_RESULT_W-1:0] CHUNK_CNT = CLZ_RESULT_W'(SCAN_WIDTH);

    clz_state_t              state_q, state_d;
    logic [31:0]             shreg_q, shreg_d;
    logic [CLZ_RESULT_W-1:0] count_q, count_d;
    logic [ITER_W-1:0]       iter_q, iter_d;
    logic                    found_q, found_d;
    logic [31:0]             result_q;

    logic [CLZ_RESULT_W-1:0] chunk_lz;
    logic                    chunk_nz;
    logic                    early_exit;

    antares_clz_chunk_encoder #(
        .SCAN_WIDTH (SCAN_WIDTH)
    ) u_chunk_encoder (
        .chunk   (shreg_q[31 -: SCAN_WIDTH]),
        .lz      (chunk_lz),
        .nonzero (chunk_nz)
    );

    always_comb begin
        state_d    = state_q;
        shreg_d    = shreg_q;
        count_d    = count_q;
        iter_d     = iter_q;
        found_d    = found_q;
`ifdef ANTARES_CLZ_EARLY_EXIT_EN
        early_exit = !found_q && chunk_nz;
`else
        early_exit = 1'b0;
`endif
        case (state_q)
            ST_IDLE: begin
                if (clz_start) begin
                    // CLO is CLZ of the inverted operand
                    shreg_d = (clz_op == CLZ_OP_CLO) ? ~clz_input_data : clz_input_data;
                    count_d = '0;
                    iter_d  = '0;
                    found_d = 1'b0;
                    state_d = ST_SCAN;
                end
            end
            ST_SCAN: begin
                if (!found_q) begin
                    if (chunk_nz) begin
                        count_d = count_q + chunk_lz;
                        found_d = 1'b1;
                    end else begin
                        count_d = count_q + CHUNK_CNT;
                        shreg_d = shreg_q << SCAN_WIDTH;
                    end
                end
                if (iter_q == LAST_ITER || early_exit) begin
                    state_d = ST_DONE;
                end else begin
                    iter_d = iter_q + 1'b1;
                end
            end
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
        if (clz_flush) begin
            state_d = ST_IDLE;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= ST_IDLE;
            shreg_q  <= '0;
            count_q  <= '0;
            iter_q   <= '0;
            found_q  <= 1'b0;
            result_q <= '0;
        end else begin
            state_q <= state_d;
            shreg_q <= shreg_d;
            count_q <= count_d;
            iter_q  <= iter_d;
            found_q <= found_d;
            // Loaded on DONE entry so the result is valid alongside the done pulse;
            // a flush forces state_d to IDLE and therefore never updates it.
            if (state_q == ST_SCAN && state_d == ST_DONE) begin
                result_q <= {{(32 - CLZ_RESULT_W){1'b0}}, count_d};
            end
        end
    end

    assign clz_busy   = (state_q != ST_IDLE);
    assign clz_done   = (state_q == ST_DONE);
    assign clz_result = result_q;

endmodule
